// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, fetch-stage state encoding
// and the default halt word used by the instruction fetch unit.
package mips_pkg;

    localparam int PC_W = 32;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// Also produces pc+4 of the live PC and the jr misalignment flag.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_pc_plus4,
    input  logic            i_take_branch,
    input  logic [31:0]     i_branch_imm,
    input  logic            i_jump,
    input  logic [25:0]     i_jump_address,
    input  logic            i_jump_reg,
    input  logic [31:0]     i_reg_target,
    output logic [PC_W-1:0] o_seq_pc,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_misaligned
);

    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_j_target;
    logic [PC_W-1:0] w_jr_target;

    assign o_seq_pc     = i_pc + 32'd4;
    // Shift truncates to 32 bits, so the two top immediate bits fall off.
    assign w_br_off     = i_branch_imm << 2;
    assign w_br_target  = i_pc_plus4 + w_br_off;
    assign w_j_target   = {i_pc_plus4[31:28], i_jump_address, 2'b00};
    assign w_jr_target  = {i_reg_target[31:2], 2'b00};
    assign o_misaligned = i_jump_reg && (i_reg_target[1:0] != 2'b00);

    always_comb begin
        o_next_pc = i_pc_plus4;
        if (i_jump_reg) begin
            o_next_pc = w_jr_target;
        end else if (i_jump) begin
            o_next_pc = w_j_target;
        end else if (i_take_branch) begin
            o_next_pc = w_br_target;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, reads one word per instruction from a
// 1-cycle synchronous memory, pulses the decoder and waits for commit.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        dec_en,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        take_branch,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_address,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    output logic        halted,
    output logic        misaligned
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pc_plus4;
    logic [31:0]     r_instr;
    logic            r_misaligned;

    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_next_pc;
    logic            w_jr_misaligned;
    logic            w_commit_exec;

    next_pc_calc u_next_pc (
        .i_pc           (r_pc),
        .i_pc_plus4     (r_pc_plus4),
        .i_take_branch  (take_branch),
        .i_branch_imm   (branch_imm),
        .i_jump         (jump),
        .i_jump_address (jump_address),
        .i_jump_reg     (jump_reg),
        .i_reg_target   (reg_target),
        .o_seq_pc       (w_seq_pc),
        .o_next_pc      (w_next_pc),
        .o_misaligned   (w_jr_misaligned)
    );

    // Qualifiers only matter when commit lands in EXEC.
    assign w_commit_exec = (r_state == S_EXEC) && commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pc_plus4   <= '0;
            r_instr      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_WAIT) begin
                r_instr    <= imem_rdata;
                r_pc_plus4 <= w_seq_pc;
            end
            if (w_commit_exec) begin
                r_pc <= w_next_pc;
                if (w_jr_misaligned) begin
                    r_misaligned <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (run) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = (imem_rdata == HALT_INSTR) ? S_HALT : S_ISSUE;
            S_ISSUE: w_state_next = S_EXEC;
            S_EXEC:  if (commit) w_state_next = run ? S_FETCH : S_IDLE;
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign imem_ren   = (r_state == S_FETCH);
    assign dec_en     = (r_state == S_ISSUE);
    assign halted     = (r_state == S_HALT);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = r_pc_plus4;
    assign instr      = r_instr;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous memory model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        dec_en;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        take_branch;
    logic [31:0] branch_imm;
    logic        jump;
    logic [25:0] jump_address;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        halted;
    logic        misaligned;

    int n_pass;
    int n_chk;
    int n_fail;

    logic [31:0] mem [logic [31:0]];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .imem_ren     (imem_ren),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .dec_en       (dec_en),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .commit       (commit),
        .take_branch  (take_branch),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_address (jump_address),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .halted       (halted),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0000;
    endfunction

    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= mem_rd(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the decoder pulse, then one more cycle into EXEC.
    task automatic to_exec(input string tag);
        int k;
        k = 0;
        while (dec_en !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk(tag, {31'b0, dec_en}, 32'd1);
        step();
    endtask

    task automatic do_commit(input logic tb_i, input logic [31:0] imm, input logic j_i,
                             input logic [25:0] ja, input logic jr_i, input logic [31:0] rt);
        commit       = 1'b1;
        take_branch  = tb_i;
        branch_imm   = imm;
        jump         = j_i;
        jump_address = ja;
        jump_reg     = jr_i;
        reg_target   = rt;
        step();
        commit      = 1'b0;
        take_branch = 1'b0;
        jump        = 1'b0;
        jump_reg    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_iss1;
        time t_iss2;
        logic any_act;
        int k;

        n_pass = 0; n_chk = 0; n_fail = 0;
        mem[32'h0] = 32'h2008_0005;
        mem[32'h4] = 32'h2008_0005;
        mem[32'h8] = 32'hFFFF_FFFF;
        imem_rdata = 32'h0;
        rst_n = 1'b0; run = 1'b1; commit = 1'b0; take_branch = 1'b0;
        branch_imm = 32'h0; jump = 1'b0; jump_address = 26'h0;
        jump_reg = 1'b0; reg_target = 32'h0;

        step();
        step();
        chk("rst imem_ren", {31'b0, imem_ren}, 32'd0);
        chk("rst dec_en", {31'b0, dec_en}, 32'd0);
        chk("rst pc", pc, 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst pc_plus4", pc_plus4, 32'h0);
        chk("rst halted", {31'b0, halted}, 32'd0);
        chk("rst misaligned", {31'b0, misaligned}, 32'd0);
        rst_n = 1'b1;

        // First fetch at RESET_PC, 4-cycle instruction period.
        step();
        chk("fetch0 ren", {31'b0, imem_ren}, 32'd1);
        chk("fetch0 addr", imem_addr, 32'h0);
        step();
        step();
        chk("issue0 dec_en", {31'b0, dec_en}, 32'd1);
        chk("issue0 instr", instr, 32'h2008_0005);
        chk("issue0 pc_plus4", pc_plus4, 32'h4);
        t_iss1 = $time;
        step();
        chk("exec0 dec_en", {31'b0, dec_en}, 32'd0);
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("fetch1 addr", imem_addr, 32'h4);
        k = 0;
        while (dec_en !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        t_iss2 = $time;
        chk("dec_en period", 32'((t_iss2 - t_iss1) / 10), 32'd4);

        // Branches from pc=0x10.
        step();
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h10);
        chk("jr 0x10 addr", imem_addr, 32'h10);
        to_exec("to_exec 10a");
        do_commit(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("branch back addr", imem_addr, 32'h0C);
        to_exec("to_exec 0c");
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("seq 0c addr", imem_addr, 32'h10);
        to_exec("to_exec 10b");
        do_commit(1'b1, 32'h3, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("branch fwd addr", imem_addr, 32'h20);

        // Priority resolution at pc=0x40.
        to_exec("to_exec 20");
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h40);
        chk("jr 0x40 addr", imem_addr, 32'h40);
        to_exec("to_exec 40a");
        do_commit(1'b1, 32'h5, 1'b1, 26'h10, 1'b0, 32'h0);
        chk("jump over branch", imem_addr, 32'h40);
        chk("misaligned still 0", {31'b0, misaligned}, 32'd0);
        to_exec("to_exec 40b");
        do_commit(1'b1, 32'h5, 1'b1, 26'h10, 1'b1, 32'h203);
        chk("jr over all addr", imem_addr, 32'h200);
        chk("misaligned set", {31'b0, misaligned}, 32'd1);

        // Commit outside EXEC must be ignored.
        commit = 1'b1; jump_reg = 1'b1; reg_target = 32'h100;
        step();
        commit = 1'b0; jump_reg = 1'b0;
        to_exec("to_exec 200");
        chk("spurious commit pc", pc, 32'h200);
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("seq 200 addr", imem_addr, 32'h204);
        chk("misaligned sticky", {31'b0, misaligned}, 32'd1);

        // run=0 at commit parks in IDLE with the updated pc.
        to_exec("to_exec 204");
        run = 1'b0;
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("idle ren", {31'b0, imem_ren}, 32'd0);
        chk("idle pc", pc, 32'h208);
        any_act = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            any_act = any_act | imem_ren | dec_en;
        end
        chk("idle no activity", {31'b0, any_act}, 32'd0);
        run = 1'b1;
        step();
        chk("resume ren", {31'b0, imem_ren}, 32'd1);
        chk("resume addr", imem_addr, 32'h208);

        // Asynchronous reset during WAIT.
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rstW pc", pc, 32'h0);
        chk("rstW pc_plus4", pc_plus4, 32'h0);
        chk("rstW misaligned", {31'b0, misaligned}, 32'd0);
        chk("rstW ren", {31'b0, imem_ren}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstW refetch addr", imem_addr, 32'h0);
        chk("rstW refetch ren", {31'b0, imem_ren}, 32'd1);

        // Halt word at 0x8.
        step(); step(); step();
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        to_exec("to_exec 4h");
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("halt fetch addr", imem_addr, 32'h8);
        chk("halt fetch halted", {31'b0, halted}, 32'd0);
        step();
        chk("halt wait halted", {31'b0, halted}, 32'd0);
        step();
        chk("halted set", {31'b0, halted}, 32'd1);
        chk("halt no dec_en", {31'b0, dec_en}, 32'd0);
        commit = 1'b1; jump_reg = 1'b1; reg_target = 32'h100;
        step();
        commit = 1'b0; jump_reg = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            any_act = any_act | imem_ren | dec_en;
        end
        chk("halt no activity", {31'b0, any_act}, 32'd0);
        chk("halt absorbing", {31'b0, halted}, 32'd1);
        chk("halt pc", pc, 32'h8);

        // Reset out of HALT, then sequential wrap-around.
        rst_n = 1'b0;
        step();
        chk("rst clears halted", {31'b0, halted}, 32'd0);
        rst_n = 1'b1;
        step();
        step(); step(); step();
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
        chk("top addr", imem_addr, 32'hFFFF_FFFC);
        to_exec("to_exec top");
        chk("wrap pc_plus4", pc_plus4, 32'h0);
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        chk("wrap addr", imem_addr, 32'h0);
        to_exec("to_exec 0w");
        do_commit(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        to_exec("to_exec 4w");
        chk("exec4 pc_plus4", pc_plus4, 32'h8);

        // Asynchronous reset during EXEC.
        #3 rst_n = 1'b0;
        #1;
        chk("rstE pc", pc, 32'h0);
        chk("rstE pc_plus4", pc_plus4, 32'h0);
        chk("rstE instr", instr, 32'h0);
        chk("rstE dec_en", {31'b0, dec_en}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstE refetch ren", {31'b0, imem_ren}, 32'd1);
        chk("rstE refetch addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage that sits directly upstream of the instruction decoder. It holds the program counter and reads one 32-bit word per instruction from a synchronous instruction memory. It presents that word to the decoder with a one-cycle enable pulse, then waits for the execute/writeback paths to commit before computing the next PC. The next PC is one of: sequential, taken branch, jump, or register jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (byte address, word aligned)
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops fetching

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  level; permits leaving IDLE
- imem_ren  out  1  instruction memory read strobe
- imem_addr  out  32  byte address of the word being read (= pc)
- imem_rdata  in  32  read data, valid in the cycle after imem_ren
- instr  out  32  captured instruction, drives decoder instr
- dec_en  out  1  one-cycle pulse, drives decoder en
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc+4 of the current instruction (link value for jal)
- commit  in  1  one-cycle strobe: current instruction finished
- take_branch  in  1  qualified with commit: Branch & alu_zero
- branch_imm  in  32  sign-extended immediate from the decoder
- jump  in  1  qualified with commit: j/jal
- jump_address  in  26  target field from the decoder
- jump_reg  in  1  qualified with commit: jr
- reg_target  in  32  rs value for jr
- halted  out  1  HALT_INSTR reached
- misaligned  out  1  sticky: a jr target had bits[1:0] != 0

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, EXEC, HALT.
- IDLE: leave for FETCH when run=1.
- FETCH: imem_ren=1, imem_addr=pc; go to WAIT unconditionally.
- WAIT: capture instr<=imem_rdata and pc_plus4<=pc+4.
  - Captured word == HALT_INSTR: go to HALT.
  - Otherwise: go to ISSUE.
- ISSUE: dec_en=1 for exactly this cycle; go to EXEC.
- EXEC: hold instr and pc stable. On commit=1, load the next PC and go to FETCH if run=1, otherwise to IDLE.
- Next-PC priority (evaluated only on commit in EXEC), all arithmetic mod 2^32:
  - jump_reg: {reg_target[31:2],2'b00}; set misaligned if reg_target[1:0]!=0.
  - jump: {pc_plus4[31:28], jump_address, 2'b00}.
  - take_branch: pc_plus4 + (branch_imm << 2); the top two shifted-out bits are dropped.
  - Otherwise: pc_plus4.
- Simultaneous qualifiers resolve by the priority above. commit outside EXEC is ignored, and so are the qualifiers.
- HALT: absorbing; halted=1, no reads, dec_en=0. Only reset exits.
- Wrap-around: pc 32'hFFFF_FFFC sequential → 32'h0000_0000.

## Timing
- Reset (async assert, any state): state=IDLE, pc=RESET_PC, instr=0, pc_plus4=0, imem_ren=0, dec_en=0, halted=0, misaligned=0. This holds mid-transaction; in-flight memory data is discarded.
- Memory latency is fixed at 1 cycle. Cycle t=FETCH (ren), t+1=WAIT (rdata sampled at end of cycle), t+2=ISSUE (dec_en high, instr stable), t+3=EXEC onward.
- The decoder registers on the edge ending t+2, so instr must not change before commit.
- commit in cycle N: pc updated at the end of N; FETCH in N+1. The minimum instruction period is 4 cycles (commit in the first EXEC cycle).
- misaligned and halted are registered; they assert the cycle after the triggering edge.

## Structure
- Shared package mips_pkg: opcode/funct constants, HALT_INSTR default, fetch state enum, PC width constant.
- Sub-module next_pc_calc: combinational priority mux and adders (pc_plus4, branch target, jump target, aligned jr target, misaligned flag). The FSM and registers stay in instr_fetch_unit.

## Test plan
- Reset with RESET_PC=0, run=1, memory [0]=0x20080005 (addi), commit 1 cycle after dec_en → imem_addr 0 then 4; dec_en period 4 cycles; instr=0x20080005, pc_plus4=4.
- Branch: pc=0x10, commit with take_branch=1, branch_imm=0xFFFFFFFE → next imem_addr=0x0C. Same with branch_imm=3 → 0x20.
- Jump vs branch simultaneous: pc=0x40, jump=1, jump_address=0x0000010, take_branch=1 → next addr 0x40; jump_reg=1 too, reg_target=0x203 → next addr 0x200, misaligned=1 and stays set.
- Halt: word HALT_INSTR at 0x8 → halted=1 two cycles after FETCH of 0x8, dec_en never pulses for it, no further imem_ren; spurious commit ignored.
- Reset mid-EXEC and mid-WAIT (rst_n low between edges) → outputs return to reset values immediately, next fetch is from RESET_PC; sequential wrap from 0xFFFFFFFC fetches 0x0.
- run=0 during EXEC, commit → IDLE, pc updated, no imem_ren until run=1.
